hazard_scoreboard: RTL

Parametrised, clocked successor to the pipeline conflict judge for the redirect (forwarding) pipeline. It tracks in-flight destination registers in a shift-register scoreboard of configurable depth and produces per-operand forward selects and load-use stalls. It also handles a non-pipelined multi-cycle mult/div unit with HI/LO structural-hazard stalls, and supports a flush that squashes the ID-stage instruction. It sits between ID decode and the EX operand muxes.

---
 rtl/hazard_scoreboard_pkg.sv | 27 ++
 rtl/hazard_src_match.sv | 33 +++
 rtl/hazard_scoreboard.sv | 101 ++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the hazard scoreboard: opcode/funct
// constants, the scoreboard entry payload and the forward-select encoding.
package hazard_scoreboard_pkg;

  // Opcodes and functs that decode hands to the scoreboard.
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  // Widest register index an entry can hold; narrower indices are zero-extended.
  localparam int unsigned RW_MAX = 8;

  // Forward select value meaning "read the register file".
  localparam int unsigned FWD_RF = 0;

  // One in-flight destination.
  typedef struct packed {
    logic              v;
    logic [RW_MAX-1:0] wd;
    logic              ld;
  } sb_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// Youngest-match priority encoder for one source operand.
//   used/src  : operand read enable and register index
//   stg       : scoreboard entries, index 1 = EX (youngest)
//   sel       : stage of youngest matching producer, 0 = register file
//   ld_hit    : youngest producer is a load not yet forwardable
module hazard_src_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned RW         = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned FW         = 2
) (
  input  logic                  used,
  input  logic [RW-1:0]         src,
  input  sb_entry_t [DEPTH:1]   stg,
  output logic [FW-1:0]         sel,
  output logic                  ld_hit
);

  // Scan oldest to youngest so the youngest match overwrites the result.
  always_comb begin
    sel    = FW'(FWD_RF);
    ld_hit = 1'b0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      if (used && (src != '0) && stg[k].v && (stg[k].wd == RW_MAX'(src))) begin
        sel    = FW'(k);
        ld_hit = stg[k].ld && (k < int'(LOAD_STAGE));
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Clocked hazard scoreboard between ID decode and the EX operand muxes.
// Tracks in-flight destinations for DEPTH stages, produces per-operand
// forward selects, load-use stalls and mult/div HI/LO structural stalls.
//   clk, rst_n          : clock, async active-low reset
//   id_*                : ID-stage instruction attributes
//   flush               : squash the ID instruction this cycle
//   stall, issue        : hold IF/ID + bubble EX / ID instruction proceeds
//   fwd_a, fwd_b        : operand selects, 0 = regfile, k = stage k result
//   md_busy             : mult/div unit occupied
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned RW         = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned MD_LAT     = 4,
  parameter int unsigned FW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic          id_rs_used,
  input  logic [RW-1:0] id_rs,
  input  logic          id_rt_used,
  input  logic [RW-1:0] id_rt,
  input  logic          id_wr,
  input  logic [RW-1:0] id_wd,
  input  logic          id_is_load,
  input  logic          id_md_start,
  input  logic          id_md_read,
  input  logic          flush,
  output logic          stall,
  output logic          issue,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic          md_busy
);

  localparam int unsigned MW = $clog2(MD_LAT + 1);

  sb_entry_t [DEPTH:1] stg;
  logic [MW-1:0]       md_cnt;
  logic                ld_a, ld_b;
  logic                md_haz;

  hazard_src_match #(
    .RW(RW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .FW(FW)
  ) u_match_a (
    .used   (id_rs_used),
    .src    (id_rs),
    .stg    (stg),
    .sel    (fwd_a),
    .ld_hit (ld_a)
  );

  hazard_src_match #(
    .RW(RW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .FW(FW)
  ) u_match_b (
    .used   (id_rt_used),
    .src    (id_rt),
    .stg    (stg),
    .sel    (fwd_b),
    .ld_hit (ld_b)
  );

  // Stall ignores flush so a redirect never masks a pending hazard.
  always_comb begin
    md_busy = (md_cnt != '0);
    md_haz  = (id_md_start | id_md_read) & md_busy;
    stall   = id_valid & (ld_a | ld_b | md_haz);
    issue   = id_valid & ~stall & ~flush;
  end

  // Destination shift register; a non-writing or squashed ID slot enters as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      for (int k = int'(DEPTH); k >= 2; k--) begin
        stg[k] <= stg[k-1];
      end
      if (issue && id_wr && (id_wd != '0)) begin
        stg[1] <= '{v: 1'b1, wd: RW_MAX'(id_wd), ld: id_is_load};
      end else begin
        stg[1] <= '0;
      end
    end
  end

  // Mult/div occupancy counter, loaded on issue and saturating at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (issue && id_md_start) begin
      md_cnt <= MW'(MD_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MW'(1);
    end
  end

endmodule
